clk_div: RTL and testbench
==========================

CLK_DIV -- requirements
Module: clk_div

Interface
REQ-001 The block SHALL have parameter DIV_WIDTH, default 4, giving the divisor width in bits; legal values are 2 to 16.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single source clock; all sequential logic runs on it.
REQ-003 The block SHALL have port arst_ni, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port div_i, input, DIV_WIDTH bits: unsigned divide ratio N.
REQ-005 The block SHALL have port clk_o, output, 1 bit: the divided clock.

Function
REQ-006 For N >= 2, clk_o SHALL be periodic with period exactly N clk_i periods.
REQ-007 For N = 0 or N = 1 (bypass), clk_o SHALL equal clk_i, with period 1 clk_i period.
REQ-008 For N >= 2, clk_o rising edges SHALL occur only on clk_i rising edges, produced by a register with no combinational glitch path.
REQ-009 For N >= 2, an internal counter SHALL count 0..N-1 and wrap to 0; clk_o SHALL rise when the counter wraps to 0.
REQ-010 For even N, clk_o SHALL be high for N/2 clk_i cycles and low for N/2 cycles (50% duty).
REQ-011 For odd N, duty cycle SHALL follow REQ-021.
REQ-012 The active divisor SHALL be a registered copy of div_i, loaded only at a period boundary (counter wrap) or on the first clk_i rising edge after reset release.
REQ-013 A div_i change SHALL never shorten or stretch the period in progress; the first full period after the change SHALL use the new N.
REQ-014 Switching between bypass and N >= 2 SHALL take effect at a period boundary, and the first clk_o rising edge of the new mode SHALL coincide with a clk_i rising edge.
REQ-015 In bypass mode the counter SHALL be held at 0.
REQ-016 Rising-edge-to-rising-edge latency from reset release to the first clk_o rising edge SHALL be 1 clk_i cycle.

Reset
REQ-017 While arst_ni = 0, clk_o SHALL be 0 immediately, with no clock required, in all modes including bypass.
REQ-018 While arst_ni = 0, the counter SHALL be 0 and the active-divisor register SHALL be 0.
REQ-019 Reset asserted mid-period SHALL abort the period; after release, operation SHALL restart per REQ-016 using the current div_i.
REQ-020 Reset release SHALL be treated as asynchronous assert / synchronous use; no glitch on clk_o at release other than the legitimate first edge.

Configuration
REQ-021 Macro CLK_DIV_ODD_DUTY50_EN SHALL select the odd-N duty behaviour:
- Defined: for odd N >= 3, clk_o high time SHALL be exactly N/2 clk_i periods (50% duty). The falling edge is taken from a clk_i falling-edge register; the period and rising edge are unchanged.
- Undefined: for odd N, clk_o SHALL be high for (N-1)/2 cycles and low for (N+1)/2 cycles, and no negative-edge logic is present.

Verification
REQ-022 arst_ni = 0 for 5 cycles, then check 1 ns after assertion at any time -> clk_o = 0.
REQ-023 Release reset, div_i = 1 -> clk_o period 10 ns with a 10 ns clk_i; div_i = 15 -> period 150 ns; div_i = 0 -> period 10 ns (bypass).
REQ-024 Sweep div_i 0..15: wait 5 cycles, then measure two consecutive clk_o rising edges -> period = max(N,1) x 10 ns every time.
REQ-025 div_i = 2, 4, 3 -> high times 10 ns, 20 ns, and 10 ns (15 ns with CLK_DIV_ODD_DUTY50_EN).
REQ-026 div_i = 3, run 15 cycles, assert reset -> clk_o = 0 after 1 ns; release after 2 cycles -> period 30 ns; repeat with div_i = 2 -> period 20 ns.
REQ-027 Change div_i 15 -> 4 mid-period -> the current 150 ns period completes, then the next period is 40 ns, with no runt pulse.

Source files
------------

// File: rtl/clk_div.sv
// Integer clock divider with glitch-free bypass (N = 0/1 passes clk_i straight through).
// Define CLK_DIV_ODD_DUTY50_EN to stretch odd-N high time by half a cycle for 50% duty.
`timescale 1ns/1ps
module clk_div #(
    parameter int unsigned DIV_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 clk_o
);

    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

    // ST_BYPASS occupies bit 1 alone so the output mux select is one flop, never a decode.
    typedef enum logic [1:0] {
        ST_START  = 2'b00,
        ST_DIVIDE = 2'b01,
        ST_BYPASS = 2'b10
    } state_e;

    state_e               state_q;
    state_e               state_d;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_d;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;
    logic [DIV_WIDTH-1:0] cnt_inc;
    logic [DIV_WIDTH-1:0] half;
    logic                 pos_q;
    logic                 pos_d;
    logic                 boundary;
    logic                 div_clk;

    assign cnt_inc  = cnt_q + ONE;
    assign half     = div_q >> 1;
    // Outside divide mode every clk_i edge is a period boundary.
    assign boundary = (state_q != ST_DIVIDE) || (cnt_q == (div_q - ONE));

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= ST_START;
            div_q   <= '0;
            cnt_q   <= '0;
            pos_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (boundary) begin
            state_d = (div_i <= ONE) ? ST_BYPASS : ST_DIVIDE;
        end
    end

    // A boundary always raises pos, which makes every mode switch land on a clk_i rise.
    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        pos_d = pos_q;
        if (boundary) begin
            div_d = div_i;
            cnt_d = '0;
            pos_d = 1'b1;
        end else begin
            cnt_d = cnt_inc;
            pos_d = (cnt_inc < half);
        end
    end

`ifdef CLK_DIV_ODD_DUTY50_EN
    logic neg_q;

    always_ff @(negedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    // neg_q trails pos_q by half a cycle, so OR-ing it extends only the falling edge.
    assign div_clk = pos_q | (div_q[0] & neg_q);
`else
    assign div_clk = pos_q;
`endif

    always_comb begin
        clk_o = div_clk;
        if (state_q[1]) begin
            clk_o = clk_i;
        end
    end

endmodule

// File: tb/tb_clk_div.sv
// Directed bench for clk_div: reset gating, bypass, period sweep, duty, reset abort, live ratio change.
`timescale 1ns/1ps
module tb_clk_div;

    logic       clk_i = 1'b0;
    logic       arst_ni;
    logic [3:0] div_i;
    logic       clk_o;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  rise_cnt = 0;
    int  fall_cnt = 0;
    time last_rise = 0;
    time last_fall = 0;
    logic [31:0] exp_q[$];

    clk_div #(.DIV_WIDTH(4)) dut (
        .clk_i  (clk_i),
        .arst_ni(arst_ni),
        .div_i  (div_i),
        .clk_o  (clk_o)
    );

    // clock / edge monitors
    always #5 clk_i = ~clk_i;

    always @(posedge clk_o) begin
        rise_cnt++;
        last_rise = $time;
    end

    always @(negedge clk_o) begin
        fall_cnt++;
        last_fall = $time;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_rise(input string tag, output time t);
        int start;
        bit ok;
        start = rise_cnt;
        ok    = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            #1;
            if (rise_cnt != start) ok = 1'b1;
        end
        check({tag, "_rise_timeout"}, longint'(ok), 1);
        t = last_rise;
    endtask

    task automatic wait_fall(input string tag, output time t);
        int start;
        bit ok;
        start = fall_cnt;
        ok    = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            #1;
            if (fall_cnt != start) ok = 1'b1;
        end
        check({tag, "_fall_timeout"}, longint'(ok), 1);
        t = last_fall;
    endtask

    initial begin
        time trel;
        time t1;
        time t2;
        time tf;
        int  fc0;
        int  exp_p;

        // reset holds clk_o low without any clock, and across clk_i highs in bypass
        arst_ni = 1'b1;
        div_i   = 4'd0;
        #1 arst_ni = 1'b0;
        #1 check("reset_no_clock", longint'(clk_o), 0);
        @(posedge clk_i);
        #1 check("reset_clk_high", longint'(clk_o), 0);
        repeat (5) @(negedge clk_i);
        check("reset_5_cycles", longint'(clk_o), 0);

        // release into bypass N=1
        div_i   = 4'd1;
        arst_ni = 1'b1;
        trel    = $time;
        wait_rise("n1_first", t1);
        check("n1_latency", longint'(t1 - trel), 5);
        wait_rise("n1_second", t2);
        check("n1_period", longint'(t2 - t1), 10);

        @(negedge clk_i);
        div_i = 4'd15;
        wait_rise("n15_a", t1);
        wait_rise("n15_b", t2);
        check("n15_period", longint'(t2 - t1), 150);

        @(negedge clk_i);
        div_i = 4'd0;
        wait_rise("n0_a", t1);
        wait_rise("n0_b", t2);
        check("n0_period", longint'(t2 - t1), 10);

        // sweep every ratio
        for (int n = 0; n < 16; n++) begin
            @(negedge clk_i);
            div_i = 4'(n);
            exp_q.push_back(32'(((n < 2) ? 1 : n) * 10));
            repeat (5) @(negedge clk_i);
            wait_rise("sweep_a", t1);
            wait_rise("sweep_b", t2);
            exp_p = int'(exp_q.pop_front());
            check($sformatf("sweep_n%0d_period", n), longint'(t2 - t1), longint'(exp_p));
        end

        // high times
        @(negedge clk_i);
        div_i = 4'd2;
        wait_rise("duty2", t1);
        wait_fall("duty2", tf);
        check("duty2_high", longint'(tf - t1), 10);

        @(negedge clk_i);
        div_i = 4'd4;
        wait_rise("duty4", t1);
        wait_fall("duty4", tf);
        check("duty4_high", longint'(tf - t1), 20);

        @(negedge clk_i);
        div_i = 4'd3;
        wait_rise("duty3", t1);
        wait_fall("duty3", tf);
        wait_rise("duty3_next", t2);
`ifdef CLK_DIV_ODD_DUTY50_EN
        check("duty3_high", longint'(tf - t1), 15);
        check("duty3_low", longint'(t2 - tf), 15);
`else
        check("duty3_high", longint'(tf - t1), 10);
        check("duty3_low", longint'(t2 - tf), 20);
`endif

        // reset mid-period, N=3
        repeat (15) @(negedge clk_i);
        #2 arst_ni = 1'b0;
        #1 check("abort3_low", longint'(clk_o), 0);
        repeat (2) @(negedge clk_i);
        arst_ni = 1'b1;
        trel    = $time;
        wait_rise("abort3_first", t1);
        check("abort3_latency", longint'(t1 - trel), 5);
        wait_rise("abort3_second", t2);
        check("abort3_period", longint'(t2 - t1), 30);

        // reset mid-period, restart with N=2
        @(negedge clk_i);
        #2 arst_ni = 1'b0;
        #1 check("abort2_low", longint'(clk_o), 0);
        div_i = 4'd2;
        repeat (2) @(negedge clk_i);
        arst_ni = 1'b1;
        trel    = $time;
        wait_rise("abort2_first", t1);
        check("abort2_latency", longint'(t1 - trel), 5);
        wait_rise("abort2_second", t2);
        check("abort2_period", longint'(t2 - t1), 20);

        // ratio change 15 -> 4 mid-period
        @(negedge clk_i);
        div_i = 4'd15;
        wait_rise("chg_start", t1);
        fc0 = fall_cnt;
        repeat (5) @(negedge clk_i);
        div_i = 4'd4;
        wait_rise("chg_end15", t2);
        check("chg_period15", longint'(t2 - t1), 150);
        check("chg_no_runt", longint'(fall_cnt - fc0), 1);
        wait_fall("chg_n4", tf);
        check("chg_high4", longint'(tf - t2), 20);
        t1 = t2;
        wait_rise("chg_n4", t2);
        check("chg_period4", longint'(t2 - t1), 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
